// File: rtl/press_generator_pkg.sv
// press_generator_pkg
//   Shared definitions for the press generator (and the input-side shaper):
//   the FSM state encoding and a helper sizing the phase counter.
package press_generator_pkg;

    // Same encoding the input-side shaper FSM uses.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter width: clog2(max(press, gap)), never less than one bit.
    // The largest load value is max-1, which always fits in clog2(max) bits.
    function automatic int cnt_width(input int press_cycles, input int gap_cycles);
        int m;
        m = (press_cycles > gap_cycles) ? press_cycles : gap_cycles;
        if (m <= 1) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/press_generator_timer.sv
// press_timer
//   Loadable down-counter timing the PRESS and GAP phases.
//   Ports:
//     clk, rst   clock, async active-high reset
//     load       load strobe; takes priority over counting
//     load_val   value loaded on load
//     cnt        current count; decrements toward 0 and holds there
//     zero       high when cnt == 0
module press_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    localparam logic [W-1:0] ONE = 1;

    assign zero = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (!zero)
            cnt <= cnt - ONE;
    end

endmodule

// File: rtl/press_generator.sv
// press_generator
//   Turns single-cycle request pulses into held active-low key presses of
//   PRESS_CYCLES cycles, each followed by GAP_CYCLES of release. Requests that
//   arrive while a press is running are counted and replayed in order.
//   Ports:
//     clk, rst   clock, async active-high reset (also forces btn_out_n high)
//     pulse_in   request; every high sample is one request
//     btn_out_n  emulated key, active low, straight from a flop
//     busy       high whenever the FSM is not IDLE
//     pending    requests accepted but not yet started (saturating)
//     overflow   sticky: a request was dropped because pending was full
module press_generator
    import press_generator_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int PEND_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              btn_out_n,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int CW = cnt_width(PRESS_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0]     PRESS_LD = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PMAX     = '1;
    localparam logic [PEND_W-1:0] ONE      = 1;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, load_val;
    logic              load, cnt_zero, start, drop;
    logic [PEND_W-1:0] pending_next;

    press_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // A new press may begin from IDLE or on the last GAP cycle, so
    // back-to-back presses run without an idle cycle between them.
    always_comb begin
        start      = ((state == IDLE) || (state == GAP && cnt_zero)) &&
                     ((pending != '0) || pulse_in);
        state_next = state;
        load       = 1'b0;
        load_val   = PRESS_LD;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PRESS;
                    load       = 1'b1;
                end
            end
            PRESS: begin
                if (cnt_zero) begin
                    state_next = GAP;
                    load       = 1'b1;
                    load_val   = GAP_LD;
                end
            end
            GAP: begin
                if (start) begin
                    state_next = PRESS;
                    load       = 1'b1;
                end else if (cnt_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // pending + pulse_in - start, saturating at PMAX. A start with nothing
    // pending consumes the current pulse, so the count is unchanged.
    always_comb begin
        drop         = (pending == PMAX) && pulse_in && !start;
        pending_next = pending;
        case ({pulse_in, start})
            2'b10:   if (!drop) pending_next = pending + ONE;
            2'b01:   pending_next = pending - ONE;
            default: pending_next = pending;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            btn_out_n <= 1'b1;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            btn_out_n <= (state_next != PRESS);
            pending   <= pending_next;
            overflow  <= overflow | drop;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_press_generator.sv
// tb_press_generator
//   Directed bench for press_generator (PRESS=4, GAP=4, PEND_W=2).
//   Expected press start edges are queued as stimulus is driven; a monitor
//   pops them when btn_out_n falls and also checks each press length.
module tb_press_generator;
    localparam int PC = 4;
    localparam int GC = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic          btn_out_n, busy, overflow;
    logic [PW-1:0] pending;

    int tests = 0;
    int fails = 0;
    int cyc;
    int exp_q[$];
    logic prev_btn;
    int   low_len;

    press_generator #(.PRESS_CYCLES(PC), .GAP_CYCLES(GC), .PEND_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .btn_out_n (btn_out_n),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: after edge k, cyc == k.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Press monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_btn = 1'b1;
            low_len  = 0;
        end else begin
            if (btn_out_n === 1'b0) begin
                if (prev_btn) begin
                    tests++;
                    assert (exp_q.size() != 0) else begin
                        fails++;
                        $error("FAIL press_start: press at edge %0d, expected none", cyc);
                    end
                    if (exp_q.size() != 0) begin
                        tests--;
                        check("press_start", cyc, exp_q.pop_front());
                    end
                    low_len = 1;
                end else begin
                    low_len++;
                end
            end else if (!prev_btn) begin
                check("press_len", low_len, PC);
            end
            prev_btn = btn_out_n;
        end
    end

    // Advance to the negedge following edge k.
    task automatic to_edge(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Make pulse_in high for exactly the sample at edge k.
    task automatic pulse_at(input int k);
        to_edge(k - 1);
        pulse_in = 1'b1;
        to_edge(k);
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, pulse_in toggling: outputs stay at reset values.
        for (int i = 0; i < 4; i++) begin
            pulse_in = i[0];
            @(negedge clk);
            check("rst_btn", btn_out_n, 1);
            check("rst_busy", busy, 0);
            check("rst_pending", 32'(pending), 0);
            check("rst_overflow", overflow, 0);
        end
        pulse_in = 1'b0;
        rst      = 1'b0;

        // Single request at edge 10: low after 10..13, high after 14..17.
        exp_q.push_back(10);
        pulse_at(10);
        for (int k = 10; k <= 17; k++) begin
            to_edge(k);
            check("single_btn", btn_out_n, (k >= 14) ? 1 : 0);
            check("single_pending", 32'(pending), 0);
        end
        check("single_busy17", busy, 1);
        to_edge(18);
        check("single_busy18", busy, 0);
        do_reset();

        // Three requests at 10, 11, 12: presses at 10, 18, 26.
        exp_q.push_back(10); exp_q.push_back(18); exp_q.push_back(26);
        pulse_at(10);
        pulse_at(11);
        check("three_pend11", 32'(pending), 1);
        pulse_at(12);
        check("three_pend12", 32'(pending), 2);
        to_edge(17);
        check("three_pend17", 32'(pending), 2);
        to_edge(18);
        check("three_pend18", 32'(pending), 1);
        to_edge(26);
        check("three_pend26", 32'(pending), 0);
        to_edge(33);
        check("three_busy33", busy, 1);
        to_edge(34);
        check("three_busy34", busy, 0);
        do_reset();

        // Overflow: requests at 10..14, edge 14 dropped, four presses.
        exp_q.push_back(10); exp_q.push_back(18); exp_q.push_back(26); exp_q.push_back(34);
        for (int k = 10; k <= 13; k++) pulse_at(k);
        check("ovf_pend13", 32'(pending), 3);
        check("ovf_flag13", overflow, 0);
        pulse_at(14);
        check("ovf_pend14", 32'(pending), 3);
        check("ovf_flag14", overflow, 1);
        to_edge(18);
        check("ovf_pend18", 32'(pending), 2);
        to_edge(42);
        check("ovf_busy42", busy, 0);
        check("ovf_pend42", 32'(pending), 0);
        check("ovf_flag42", overflow, 1);
        to_edge(50);
        check("ovf_flag50", overflow, 1);
        do_reset();

        // Boundary: second request sampled on the final GAP edge (cnt==0,
        // nothing pending) starts at that same edge with no idle cycle.
        exp_q.push_back(10); exp_q.push_back(18);
        pulse_at(10);
        to_edge(17);
        check("bnd_busy17", busy, 1);
        check("bnd_pend17", 32'(pending), 0);
        pulse_at(18);
        check("bnd_busy18", busy, 1);
        check("bnd_btn18", btn_out_n, 0);
        check("bnd_pend18", 32'(pending), 0);
        to_edge(25);
        check("bnd_busy25", busy, 1);
        to_edge(26);
        check("bnd_busy26", busy, 0);
        do_reset();

        // Reset mid-press with two requests queued.
        exp_q.push_back(10);
        pulse_at(10);
        pulse_at(11);
        pulse_at(12);
        check("mid_pend12", 32'(pending), 2);
        check("mid_btn12", btn_out_n, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_btn_async", btn_out_n, 1);
        check("mid_pend_async", 32'(pending), 0);
        check("mid_busy_async", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        to_edge(30);
        check("mid_busy30", busy, 0);
        check("mid_pend30", 32'(pending), 0);
        check("mid_btn30", btn_out_n, 1);
        exp_q.push_back(32);
        pulse_at(32);
        check("mid_btn32", btn_out_n, 0);
        to_edge(40);
        check("mid_busy40", busy, 0);
        check("mid_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
